// File: rtl/memory_arbiter_pkg.sv
// Shared types for the cache-side memory arbiter: RAM word, RAM port status,
// and the arbiter FSM state encoding.
package memory_arbiter_pkg;

  typedef logic [31:0] word_t;

  // Status reported by the RAM port every cycle.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter FSM: idle, icache granted, dcache granted.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

  localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/memory_arbiter.sv
// Arbiter between the icache and dcache for the single RAM port.
// The dcache wins ties, but after STARVE_MAX consecutive dcache completions
// with an icache request pending, the icache is granted next.
//
// Handshake: a cache raises its request line(s) and holds address/data stable
// while its wait is 1; wait drops to 0 for exactly the cycle the RAM reports
// ACCESS, and the load bus is valid only in that cycle. Dropping the request
// before ACCESS aborts the transaction without a completion pulse.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic       CLK,
  input  logic       RST,
  // icache side
  input  logic       iREN,
  input  word_t      iaddr,
  output logic       iwait,
  output word_t      iload,
  // dcache side
  input  logic       dREN,
  input  logic       dWEN,
  input  word_t      daddr,
  input  word_t      dstore,
  output logic       dwait,
  output word_t      dload,
  // RAM side
  output logic       ramREN,
  output logic       ramWEN,
  output word_t      ramaddr,
  output word_t      ramstore,
  input  word_t      ramload,
  input  ramstate_t  ramstate,
  output logic       ram_err,
  // debug visibility of the FSM and starvation counter
  output arb_state_t dbg_state,
  output logic [7:0] dbg_starve
);

  localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_t       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             is_write;
  logic             d_req;
  logic             i_forced;

  assign d_req    = dREN | dWEN;
  assign i_forced = iREN && (starve_cnt >= STARVE_LIM);

  assign dbg_state  = state;
  assign dbg_starve = 8'(starve_cnt);

  // Grant FSM, starvation counter, latched dcache access kind and sticky error flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      is_write   <= 1'b0;
      ram_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req && !i_forced) begin
            state    <= DGNT;
            is_write <= dWEN;
          end else if (iREN) begin
            state <= IGNT;
          end
        end
        IGNT: begin
          if (!iREN) begin
            state <= IDLE;
          end else if (ramstate == ERROR) begin
            ram_err <= 1'b1;
          end else if (ramstate == ACCESS) begin
            starve_cnt <= '0;
            state      <= IDLE;
          end
        end
        DGNT: begin
          if (!d_req) begin
            state <= IDLE;
          end else if (ramstate == ERROR) begin
            ram_err <= 1'b1;
          end else if (ramstate == ACCESS) begin
            state <= IDLE;
            if (iREN) begin
              if (starve_cnt < STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
            end else begin
              starve_cnt <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM strobes, address/data steering and completion signalling for the granted cache.
  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      IGNT: begin
        if (iREN) begin
          ramaddr = iaddr;
          if (ramstate != ERROR) ramREN = 1'b1;
          if (ramstate == ACCESS) begin
            iwait = 1'b0;
            iload = ramload;
          end
        end
      end
      DGNT: begin
        if (d_req) begin
          ramaddr  = daddr;
          ramstore = dstore;
          if (ramstate != ERROR) begin
            ramWEN = is_write;
            ramREN = !is_write;
          end
          if (ramstate == ACCESS) begin
            dwait = 1'b0;
            dload = is_write ? '0 : ramload;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
